pipo_arbiter: RTL and testbench

- Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in/parallel-out storage register between NREQ writers.
- Each writer raises a request with its data word. The block grants one writer at a time, loads that writer's word into the register, acknowledges it, then rotates priority.
- Sits between multiple producer blocks and the shared PIPO register bank.

---
 rtl/pipo_arb_pkg.sv | 33 +++
 rtl/pipo_reg.sv | 19 +
 rtl/pipo_arbiter.sv | 107 ++++++++++
 tb/tb_pipo_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and the round-robin pick helper for the PIPO register arbiter.
package pipo_arb_pkg;

   localparam int unsigned MAXREQ = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   // First set bit of req at or above ptr, wrapping modulo n.
   function automatic logic [2:0] rr_pick(input logic [MAXREQ-1:0] req,
                                          input logic [2:0]        ptr,
                                          input int unsigned       n);
      logic [2:0]  win;
      logic        found;
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAXREQ; i++) begin
         if (i < n) begin
            idx = (32'(ptr) + i) % n;
            if (!found && req[idx[2:0]]) begin
               win   = idx[2:0];
               found = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out storage register with synchronous reset and load enable.
module pipo_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter that sequences loads from NREQ writers into one shared PIPO register.
module pipo_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2,
   parameter int PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      dataout,
   output logic [PTRW-1:0]       owner,
   output logic                  busy
);

   state_t          state, state_nx;
   logic [PTRW-1:0] win, win_nx;
   logic [PTRW-1:0] ptr, ptr_nx;
   logic [NREQ-1:0] gnt_nx, ack_nx;
   logic [2:0]      pick;
   logic            load;
   logic            req_win;
   logic [WIDTH-1:0] word;

   assign pick    = rr_pick(MAXREQ'(req), 3'(ptr), NREQ);
   // gnt is onehot(win) throughout GRANT, so it doubles as the winner mask
   assign req_win = |(req & gnt);
   assign busy    = (state != IDLE);

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == PTRW'(i))
            word = data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         win   <= '0;
         ptr   <= '0;
         gnt   <= '0;
         ack   <= '0;
         owner <= '0;
      end else begin
         state <= state_nx;
         win   <= win_nx;
         ptr   <= ptr_nx;
         gnt   <= gnt_nx;
         ack   <= ack_nx;
         if (load)
            owner <= win;
      end
   end

   always_comb begin
      state_nx = state;
      win_nx   = win;
      ptr_nx   = ptr;
      gnt_nx   = gnt;
      ack_nx   = '0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            gnt_nx = '0;
            if (|req) begin
               state_nx = GRANT;
               win_nx   = PTRW'(pick);
               gnt_nx   = NREQ'(1) << pick;
            end
         end
         GRANT: begin
            if (req_win) begin
               load     = 1'b1;
               state_nx = ACK;
               ack_nx   = gnt;
            end else begin
               state_nx = IDLE;
               gnt_nx   = '0;
            end
         end
         ACK: begin
            state_nx = IDLE;
            gnt_nx   = '0;
            ptr_nx   = (win == PTRW'(NREQ-1)) ? '0 : win + 1'b1;
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
         end
      endcase
   end

   pipo_reg #(.WIDTH(WIDTH)) u_store (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .d     (word),
      .q     (dataout)
   );

endmodule

// File: tb/tb_pipo_arbiter.sv
// Directed plus randomized bench for pipo_arbiter against a transaction-level round-robin model.
module tb_pipo_arbiter;

   localparam int WIDTH = 4;
   localparam int NREQ  = 2;
   localparam int PTRW  = 1;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      dataout;
   logic [PTRW-1:0]       owner;
   logic                  busy;

   int tests = 0;
   int fails = 0;

   int               m_ptr   = 0;
   logic [WIDTH-1:0] m_dout  = '0;
   int               m_owner = 0;

   pipo_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .PTRW(PTRW)) dut (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .data    (data),
      .gnt     (gnt),
      .ack     (ack),
      .dataout (dataout),
      .owner   (owner),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      int k;
      for (int i = 0; i < NREQ; i++) begin
         k = (p + i) % NREQ;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".gnt"},  32'(gnt), 32'd0);
      check({tag, ".ack"},  32'(ack), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".dout"}, 32'(dataout), 32'(m_dout));
      check({tag, ".own"},  32'(owner), 32'(m_owner));
   endtask

   // One full request/grant/ack (or abort) exchange starting from IDLE.
   task automatic transfer(input logic [NREQ-1:0] r, input bit abort_it,
                           input bit scramble, input string tag);
      int w;
      logic [NREQ-1:0] oh;
      req = r;
      w   = pick(r, m_ptr);
      oh  = NREQ'(1) << w;
      tick();
      check({tag, ".gnt1"},  32'(gnt), 32'(oh));
      check({tag, ".ack1"},  32'(ack), 32'd0);
      check({tag, ".busy1"}, 32'(busy), 32'd1);
      if (abort_it) begin
         req = scramble ? (NREQ'($urandom) & ~oh) : (req & ~oh);
         tick();
         check_idle({tag, ".abort"});
      end else begin
         if (scramble) req = (NREQ'($urandom) & ~oh) | oh;
         tick();
         m_dout  = data[w*WIDTH +: WIDTH];
         m_owner = w;
         check({tag, ".ack2"},  32'(ack), 32'(oh));
         check({tag, ".gnt2"},  32'(gnt), 32'(oh));
         check({tag, ".dout2"}, 32'(dataout), 32'(m_dout));
         check({tag, ".own2"},  32'(owner), 32'(m_owner));
         check({tag, ".busy2"}, 32'(busy), 32'd1);
         req = scramble ? (NREQ'($urandom) & ~oh) : (req & ~oh);
         tick();
         m_ptr = (w + 1) % NREQ;
         check_idle({tag, ".end"});
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 2'b11;
      data  = 8'h5A;

      // Reset held two cycles with both requests pending
      tick();
      check_idle("rst0");
      tick();
      check_idle("rst1");
      reset = 1'b0;

      // Single request straight out of reset
      data = {4'h7, 4'hA};
      transfer(2'b01, 1'b0, 1'b0, "single");
      check("single.val", 32'(dataout), 32'hA);

      // Bring pointer back to 0 via requester 1
      data = {4'h9, 4'hA};
      transfer(2'b10, 1'b0, 1'b0, "single1");

      // Contention: req0 first, then req1
      data = {4'h5, 4'h3};
      transfer(2'b11, 1'b0, 1'b0, "cont0");
      check("cont0.val", 32'(dataout), 32'h3);
      transfer(2'b10, 1'b0, 1'b0, "cont1");
      check("cont1.val", 32'(dataout), 32'h5);
      check("cont1.own", 32'(owner), 32'd1);

      // Abort: req0 drops during GRANT; pointer must stay at 0
      data = {4'hE, 4'hD};
      transfer(2'b01, 1'b1, 1'b0, "abort");
      transfer(2'b11, 1'b0, 1'b0, "postabort");
      check("postabort.val", 32'(dataout), 32'hD);

      // Saturation: both keep requesting; grants alternate
      data = {4'h6, 4'h1};
      for (int i = 0; i < 6; i++)
         transfer(2'b11, 1'b0, 1'b0, $sformatf("sat%0d", i));

      // No request keeps the block idle
      req = '0;
      tick();
      check_idle("noreq");

      // Reset during ACK after loading 4'hC
      data = {4'h0, 4'hC};
      m_ptr = pick(2'b11, m_ptr) == 0 ? m_ptr : m_ptr;
      req = 2'b01;
      tick();
      check("midrst.gnt", 32'(gnt), 32'h1);
      tick();
      check("midrst.ack", 32'(ack), 32'h1);
      check("midrst.dout", 32'(dataout), 32'hC);
      reset = 1'b1;
      req   = 2'b11;
      tick();
      m_ptr = 0; m_dout = '0; m_owner = 0;
      check_idle("midrst");
      reset = 1'b0;
      data  = {4'h2, 4'h8};
      transfer(2'b11, 1'b0, 1'b0, "afterrst");

      // Randomized traffic with aborts and late request changes
      for (int i = 0; i < 40; i++) begin
         logic [NREQ-1:0] r;
         data = NREQ*WIDTH'($urandom);
         r    = NREQ'($urandom_range(0, 3));
         if (r == '0) begin
            req = '0;
            tick();
            check_idle($sformatf("rnd%0d.idle", i));
         end else begin
            transfer(r, $urandom_range(0, 4) == 0, 1'b1, $sformatf("rnd%0d", i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
